jpeg_encode_info_fifo_writer: RTL
=================================

// Module: jpeg_encode_info_fifo_writer
// PURPOSE
//  Write-side front end of the JPEG encode-info FIFO (wclk domain). Takes one info record per
//  encoded frame (id, byte length, error flag) from the JPEG encoder via valid/ready. Emits it as
//  two consecutive 32-bit FIFO writes: header, then length. A record is only started when the
//  FIFO has room for both words, so the read side never sees a half record.
// PARAMETERS
//  WR_DEPTH_WIDTH  9      FIFO write address width; depth = 2**WR_DEPTH_WIDTH words
//  DROP_ON_FULL    1      1: drop a record that does not fit; 0: hold it until room appears
//  SYNC_BYTE       8'hA5  marker placed in header bits [31:24]
// PORTS
//  wclk                 in   1      write-domain clock
//  wrst                 in   1      async reset, active-high
//  info_valid           in   1      record offered by encoder
//  info_ready           out  1      writer can accept a record
//  info_frame_id        in   16     frame index
//  info_frame_len       in   32     encoded frame length in bytes
//  info_err             in   1      encoder error flag for this frame
//  fifo_wfull           in   1      FIFO ctrl wfull
//  fifo_wr_water_level  in   WR_DEPTH_WIDTH+1  FIFO ctrl wr_water_level
//  fifo_w_en            out  1      FIFO write enable
//  fifo_wdata           out  32     FIFO write data
//  rec_cnt              out  16     records fully written (wraps)
//  drop_cnt             out  16     records dropped (saturates at 16'hFFFF)
//  busy                 out  1      hold register occupied or FSM not IDLE
// BEHAVIOUR
//  - Reset: wclk is the clock; wrst is asynchronous, active-high.
//    - Reset values: state=IDLE, hold_vld=0, info_ready=1, fifo_w_en=0, fifo_wdata=0,
//      rec_cnt=0, drop_cnt=0, busy=0.
//    - wrst is the same net as the FIFO ctrl wrst, so a reset mid-record clears both sides.
//      No partial record survives.
//  - Hold register: captures id/len/err on info_valid&&info_ready, and sets hold_vld on the next edge.
//    - info_ready = !hold_vld (registered source); there is no skid stage.
//  - FSM IDLE/HDR/LEN:
//    - IDLE & hold_vld & room -> HDR; room = (fifo_wr_water_level <= 2**WR_DEPTH_WIDTH-2).
//    - IDLE & hold_vld & !room & DROP_ON_FULL=1 -> stay IDLE, clear hold_vld, drop_cnt+1 (saturating).
//    - IDLE & hold_vld & !room & DROP_ON_FULL=0 -> stay IDLE and re-evaluate every cycle.
//    - HDR: fifo_w_en = !fifo_wfull, fifo_wdata = {SYNC_BYTE, info_err, 7'b0, frame_id}.
//      Advance to LEN only on a cycle with fifo_w_en=1.
//    - LEN: fifo_w_en = !fifo_wfull, fifo_wdata = frame_len. On write: -> IDLE, clear hold_vld, rec_cnt+1.
//  - fifo_w_en and fifo_wdata are combinational from state/hold registers.
//    - fifo_w_en is never high while fifo_wfull=1. fifo_wdata=0 when fifo_w_en=0.
//  - Latency with no stall, accept at edge N:
//    - header written in cycle N+2, length in cycle N+3.
//    - info_ready high again in N+4, giving a throughput of 1 record per 4 cycles.
//  - wr_water_level lags one cycle but already counts the current write.
//    The room check therefore stays conservative, because a new record starts at most once per 4 cycles.
//  - Simultaneous events:
//    - info_valid is ignored while hold_vld=1.
//    - A drop and an accept cannot happen in the same cycle: ready is low during the drop decision.
//  - Counters wrap (rec_cnt) or saturate (drop_cnt) silently. They are cleared only by wrst.
// TESTING
//  1 Single record id=16'h0003, len=32'h0000_1A2B, err=0 into empty FIFO ->
//    writes 32'hA500_0003 then 32'h0000_1A2B on consecutive cycles; rec_cnt=1.
//  2 err=1, id=16'hFFFF -> header 32'hA580_FFFF; length word unchanged.
//  3 level=511 (depth 512), DROP_ON_FULL=1, record offered -> no fifo_w_en, drop_cnt=1, info_ready back high.
//  4 Same as 3 with DROP_ON_FULL=0; level then falls to 510 -> record written, drop_cnt=0.
//  5 fifo_wfull forced high for 3 cycles while in LEN -> fifo_w_en low for those 3 cycles.
//    Length word is written exactly once afterwards.
//  6 wrst pulsed in the HDR cycle -> all outputs return to reset values; the next record is written complete.

Source files
------------

// File: rtl/jpeg_encode_info_fifo_writer.sv
// Write-side front end of the JPEG encode-info FIFO.
// Buffers one info record and emits it as a header word followed by a length word.
module jpeg_encode_info_fifo_writer #(
    parameter int unsigned WR_DEPTH_WIDTH = 9,
    parameter bit          DROP_ON_FULL   = 1'b1,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic                    wclk,
    input  logic                    wrst,
    input  logic                    info_valid,
    output logic                    info_ready,
    input  logic [15:0]             info_frame_id,
    input  logic [31:0]             info_frame_len,
    input  logic                    info_err,
    input  logic                    fifo_wfull,
    input  logic [WR_DEPTH_WIDTH:0] fifo_wr_water_level,
    output logic                    fifo_w_en,
    output logic [31:0]             fifo_wdata,
    output logic [15:0]             rec_cnt,
    output logic [15:0]             drop_cnt,
    output logic                    busy
);

    localparam int unsigned DEPTH = 1 << WR_DEPTH_WIDTH;
    localparam logic [WR_DEPTH_WIDTH:0] ROOM_MAX =
        (WR_DEPTH_WIDTH+1)'(DEPTH - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_LEN
    } state_e;

    state_e      state_q, state_d;
    logic        hold_vld_q, hold_vld_d;
    logic [15:0] id_q;
    logic [31:0] len_q;
    logic        err_q;
    logic [15:0] rec_cnt_q, rec_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic        accept;
    logic        room;

    assign accept = info_valid && !hold_vld_q;
    // Both words must fit before a record is started.
    assign room   = (fifo_wr_water_level <= ROOM_MAX);

    always_comb begin
        state_d    = state_q;
        hold_vld_d = hold_vld_q;
        rec_cnt_d  = rec_cnt_q;
        drop_cnt_d = drop_cnt_q;
        fifo_w_en  = 1'b0;
        fifo_wdata = '0;
        if (accept) begin
            hold_vld_d = 1'b1;
        end
        unique case (state_q)
            S_IDLE: begin
                if (hold_vld_q) begin
                    if (room) begin
                        state_d = S_HDR;
                    end else if (DROP_ON_FULL) begin
                        hold_vld_d = 1'b0;
                        if (drop_cnt_q != 16'hFFFF) begin
                            drop_cnt_d = drop_cnt_q + 16'd1;
                        end
                    end
                end
            end
            S_HDR: begin
                if (!fifo_wfull) begin
                    fifo_w_en  = 1'b1;
                    fifo_wdata = {SYNC_BYTE, err_q, 7'b0, id_q};
                    state_d    = S_LEN;
                end
            end
            S_LEN: begin
                if (!fifo_wfull) begin
                    fifo_w_en  = 1'b1;
                    fifo_wdata = len_q;
                    state_d    = S_IDLE;
                    hold_vld_d = 1'b0;
                    rec_cnt_d  = rec_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state_q    <= S_IDLE;
            hold_vld_q <= 1'b0;
            rec_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_vld_q <= hold_vld_d;
            rec_cnt_q  <= rec_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            id_q  <= '0;
            len_q <= '0;
            err_q <= 1'b0;
        end else if (accept) begin
            id_q  <= info_frame_id;
            len_q <= info_frame_len;
            err_q <= info_err;
        end
    end

    assign info_ready = !hold_vld_q;
    assign rec_cnt    = rec_cnt_q;
    assign drop_cnt   = drop_cnt_q;
    assign busy       = hold_vld_q || (state_q != S_IDLE);

endmodule
